instruction_fetch_unit: RTL and testbench

//  Fetch stage of the RISC-V core; sits directly upstream of the decode/Control stage.

---
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues sequential word fetches, buffers in-order memory responses,
// and discards responses belonging to a fetch stream killed by a redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    // Both ports use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high. Request valid never waits on ready. Responses carry
    // no ready; they arrive in request order and are always accepted.
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [6:0]  opcode_o,
    output logic        misalign_o,
    output logic        state_o
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);
    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [0:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   inst_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic          req_fire;
    logic          resp_seen;
    logic          push;
    logic          pop;

    assign req_fire  = imem_req_valid_o && imem_req_ready_i;
    assign resp_seen = imem_resp_valid_i && (outstanding != '0);
    assign push      = resp_seen && (drop == '0) && !redirect_i;
    assign pop       = inst_valid_o && inst_ready_i && !redirect_i;

    // Buffered plus in-flight never exceeds the FIFO size, so a push always has room.
    assign imem_req_valid_o = !reset && (state == ST_RUN) && !redirect_i
                              && (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    assign imem_addr_o      = fetch_pc;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire)  outstanding_next = outstanding_next + CW'(1);
        if (resp_seen) outstanding_next = outstanding_next - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_i) begin
                // Everything still in flight belongs to the dead stream.
                fetch_pc <= redirect_pc_i;
                resp_pc  <= redirect_pc_i;
                drop     <= outstanding_next;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                state    <= (redirect_pc_i[1:0] != 2'b00) ? ST_HALT : ST_RUN;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (resp_seen && (drop != '0)) drop <= drop - CW'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_resp_data_i;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    assign inst_valid_o = (count != '0);
    assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : NOP;
    assign pc_o         = inst_valid_o ? pc_mem[rd_ptr] : 32'h0;
    assign pc_plus4_o   = pc_o + 32'd4;
    assign opcode_o     = inst_o[6:0];
    assign misalign_o   = (state == ST_HALT);
    assign state_o      = state;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model plus a stream-level
// reference (epochs, per-stream expected PC queue) checked every cycle.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [6:0]  opcode_o;
    logic        misalign_o;
    logic        state_dbg;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o(imem_addr_o), .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_data_i(imem_resp_data_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .inst_o(inst_o), .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o), .opcode_o(opcode_o), .misalign_o(misalign_o),
        .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    int          buffered = 0;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          mem_lat = 1;
    int          mem_jit = 0;
    logic        halted = 1'b0;
    logic [31:0] exp_fetch = RESET_PC;
    int          pop_cnt = 0;
    logic [31:0] first_pop_pc = 32'h0;
    logic [31:0] last_pop_pc = 32'h0;
    logic        wrap_seen = 1'b0;
    logic [31:0] wrap_p4 = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    // One clock cycle: drive inputs at the negedge, check against the model, advance the model.
    task automatic drive_cycle(input logic redir, input logic [31:0] rpc,
                               input logic mrdy, input logic drdy);
        logic        resp, fire, popd, exp_req, exp_valid;
        logic [31:0] exp_pc, exp_inst, req_addr;
        logic [6:0]  exp_op;
        mreq_t       old_r, new_r;
        int          due;
        resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        redirect_i        = redir;
        redirect_pc_i     = rpc;
        imem_req_ready_i  = mrdy;
        inst_ready_i      = drdy;
        imem_resp_valid_i = resp;
        imem_resp_data_i  = resp ? (mem_q[0].addr ^ KEY) : $urandom;
        #1;
        exp_req = !halted && !redir && ((mem_q.size() + buffered) < DEPTH);
        n_checks++;
        if (imem_req_valid_o !== exp_req) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid_o, exp_req);
        end
        if (exp_req && imem_req_valid_o === 1'b1) begin
            n_checks++;
            if (imem_addr_o !== exp_fetch) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_addr_o, exp_fetch);
            end
        end
        exp_valid = (buffered > 0);
        n_checks++;
        if (inst_valid_o !== exp_valid) begin
            n_fail++;
            $display("FAIL inst_valid cyc=%0d: got %b expected %b", cyc, inst_valid_o, exp_valid);
        end
        if (exp_valid) begin
            exp_pc   = exp_q[0];
            exp_inst = exp_pc ^ KEY;
        end else begin
            exp_pc   = 32'h0;
            exp_inst = NOP;
        end
        exp_op = exp_inst[6:0];
        n_checks++;
        if (inst_o !== exp_inst || pc_o !== exp_pc || opcode_o !== exp_op) begin
            n_fail++;
            $display("FAIL head cyc=%0d: got inst=%h pc=%h op=%h expected inst=%h pc=%h op=%h",
                     cyc, inst_o, pc_o, opcode_o, exp_inst, exp_pc, exp_op);
        end
        if (exp_valid) begin
            n_checks++;
            if (pc_plus4_o !== exp_pc + 32'd4) begin
                n_fail++;
                $display("FAIL pc_plus4 cyc=%0d: got %h expected %h", cyc, pc_plus4_o, exp_pc + 32'd4);
            end
        end
        n_checks++;
        if (misalign_o !== halted) begin
            n_fail++;
            $display("FAIL misalign cyc=%0d: got %b expected %b", cyc, misalign_o, halted);
        end
        fire     = (imem_req_valid_o === 1'b1) && mrdy;
        req_addr = imem_addr_o;
        popd     = (inst_valid_o === 1'b1) && drdy && !redir;
        if (popd) begin
            if (pop_cnt == 0) first_pop_pc = pc_o;
            last_pop_pc = pc_o;
            pop_cnt++;
            if (pc_o === 32'hFFFF_FFFC) begin
                wrap_seen = 1'b1;
                wrap_p4   = pc_plus4_o;
            end
        end
        @(posedge clk);
        if (resp) begin
            old_r = mem_q.pop_front();
            if (old_r.epoch == epoch && !redir) buffered++;
        end
        if (fire) begin
            due = cyc + mem_lat + $urandom_range(0, mem_jit);
            if (due <= last_due) due = last_due + 1;
            last_due    = due;
            new_r.addr  = req_addr;
            new_r.due   = due;
            new_r.epoch = epoch;
            mem_q.push_back(new_r);
            exp_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (popd && buffered > 0) begin
            buffered--;
            exp_q.delete(0);
        end
        if (redir) begin
            epoch++;
            buffered = 0;
            exp_q.delete();
            exp_fetch = rpc;
            halted    = (rpc[1:0] != 2'b00);
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting between edges; outputs must react before any clock edge.
    task automatic do_reset();
        redirect_i        = 1'b0;
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b0;
        inst_ready_i      = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req=%b valid=%b mis=%b expected 0 0 0",
                     imem_req_valid_o, inst_valid_o, misalign_o);
        end
        n_checks++;
        if (inst_o !== NOP || pc_o !== 32'h0 || opcode_o !== 7'h13) begin
            n_fail++;
            $display("FAIL reset_head: got inst=%h pc=%h op=%h expected %h 0 13", inst_o, pc_o, opcode_o, NOP);
        end
        mem_q.delete();
        exp_q.delete();
        buffered  = 0;
        halted    = 1'b0;
        exp_fetch = RESET_PC;
        last_due  = 0;
        epoch++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (imem_req_valid_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: got valid=%b addr=%h expected 1 %h", imem_req_valid_o, imem_addr_o, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        mem_lat = 1;
        mem_jit = 0;
        pop_cnt = 0;
        repeat (20) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (pop_cnt < 8) begin
            n_fail++;
            $display("FAIL seq_count: got %0d pops expected at least 8", pop_cnt);
        end
        n_checks++;
        if (first_pop_pc !== RESET_PC || last_pop_pc !== RESET_PC + 32'(4 * (pop_cnt - 1))) begin
            n_fail++;
            $display("FAIL seq_order: got first=%h last=%h expected first=%h last=%h", first_pop_pc,
                     last_pop_pc, RESET_PC, RESET_PC + 32'(4 * (pop_cnt - 1)));
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_inst;
        do_reset();
        mem_lat = 1;
        pop_cnt = 0;
        repeat (8) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        exp_inst = RESET_PC ^ KEY;
        n_checks++;
        if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b1 || pc_o !== RESET_PC || inst_o !== exp_inst) begin
            n_fail++;
            $display("FAIL stall_hold: got req=%b valid=%b pc=%h inst=%h expected 0 1 %h %h",
                     imem_req_valid_o, inst_valid_o, pc_o, inst_o, RESET_PC, exp_inst);
        end
        repeat (12) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (pop_cnt < 4 || first_pop_pc !== RESET_PC || last_pop_pc !== RESET_PC + 32'(4 * (pop_cnt - 1))) begin
            n_fail++;
            $display("FAIL stall_drain: got pops=%0d first=%h last=%h expected >=4 from %h in order",
                     pop_cnt, first_pop_pc, last_pop_pc, RESET_PC);
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        mem_lat = 3;
        mem_jit = 0;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (mem_q.size() < 2) begin
            n_fail++;
            $display("FAIL drop_setup: got %0d outstanding expected 2 within 10 cycles", mem_q.size());
        end
        drive_cycle(1'b1, 32'h0040_0100, 1'b1, 1'b1);
        redirect_i = 1'b0;
        #1;
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_flush: got inst_valid=%b expected 0", inst_valid_o);
        end
        pop_cnt = 0;
        for (int i = 0; i < 40 && pop_cnt == 0; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (pop_cnt == 0 || first_pop_pc !== 32'h0040_0100) begin
            n_fail++;
            $display("FAIL drop_first: got pops=%0d pc=%h expected pc 00400100", pop_cnt, first_pop_pc);
        end
    endtask

    task automatic test_back_to_back();
        mem_lat = 2;
        drive_cycle(1'b1, 32'h0040_0300, 1'b1, 1'b1);
        drive_cycle(1'b1, 32'h0040_0400, 1'b1, 1'b1);
        pop_cnt = 0;
        for (int i = 0; i < 40 && pop_cnt == 0; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (pop_cnt == 0 || first_pop_pc !== 32'h0040_0400) begin
            n_fail++;
            $display("FAIL b2b_first: got pops=%0d pc=%h expected pc 00400400", pop_cnt, first_pop_pc);
        end
    endtask

    task automatic test_misalign();
        drive_cycle(1'b1, 32'h0040_0102, 1'b1, 1'b1);
        repeat (6) begin
            redirect_i = 1'b0;
            #1;
            n_checks++;
            if (misalign_o !== 1'b1 || imem_req_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold: got mis=%b req=%b expected 1 0", misalign_o, imem_req_valid_o);
            end
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        end
        drive_cycle(1'b1, 32'h0040_0200, 1'b1, 1'b1);
        redirect_i = 1'b0;
        #1;
        n_checks++;
        if (misalign_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h0040_0200) begin
            n_fail++;
            $display("FAIL halt_exit: got mis=%b req=%b addr=%h expected 0 1 00400200",
                     misalign_o, imem_req_valid_o, imem_addr_o);
        end
        pop_cnt = 0;
        for (int i = 0; i < 40 && pop_cnt == 0; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (pop_cnt == 0 || first_pop_pc !== 32'h0040_0200) begin
            n_fail++;
            $display("FAIL halt_restart: got pops=%0d pc=%h expected pc 00400200", pop_cnt, first_pop_pc);
        end
    endtask

    task automatic test_reset_midflight();
        mem_lat = 3;
        repeat (6) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        do_reset();
        #1;
        n_checks++;
        if (imem_req_valid_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            n_fail++;
            $display("FAIL midreset_req: got valid=%b addr=%h expected 1 %h", imem_req_valid_o, imem_addr_o, RESET_PC);
        end
        pop_cnt = 0;
        repeat (10) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (pop_cnt == 0 || first_pop_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL midreset_first: got pops=%0d pc=%h expected pc %h", pop_cnt, first_pop_pc, RESET_PC);
        end
    endtask

    task automatic test_idle_wrap();
        logic [31:0] exp_last;
        do_reset();
        mem_lat = 1;
        mem_jit = 0;
        repeat (3) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || opcode_o !== 7'h13 || pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_head: got valid=%b inst=%h op=%h pc=%h expected 0 %h 13 0",
                     inst_valid_o, inst_o, opcode_o, pc_o, NOP);
        end
        drive_cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        wrap_seen = 1'b0;
        pop_cnt   = 0;
        repeat (12) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (wrap_seen !== 1'b1 || wrap_p4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_p4: got seen=%b pc_plus4=%h expected 1 00000000", wrap_seen, wrap_p4);
        end
        exp_last = 32'hFFFF_FFFC + 32'(4 * (pop_cnt - 1));
        n_checks++;
        if (pop_cnt < 3 || last_pop_pc !== exp_last) begin
            n_fail++;
            $display("FAIL wrap_seq: got pops=%0d last=%h expected >=3 last=%h", pop_cnt, last_pop_pc, exp_last);
        end
    endtask

    task automatic test_random();
        logic        redir;
        logic [31:0] rpc;
        mem_lat = 1;
        mem_jit = 3;
        for (int i = 0; i < 1500; i++) begin
            redir = ($urandom_range(0, 19) == 0);
            rpc   = ($urandom & 32'h0000_FFFC) | 32'h0040_0000;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            drive_cycle(redir, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            if (i == 750) do_reset();
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_back_to_back();
        test_misalign();
        test_reset_midflight();
        test_idle_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got no completion by 1000000 ns expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
